mips_muldiv: RTL and testbench
==============================

# mips_muldiv

Iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It executes the R-type mult, multu, div and divu operations, which the ALU decoder leaves undefined, plus the HI/LO moves (mthi, mtlo, mfhi, mflo). It sits beside the EX-stage ALU. Hazard logic stalls on `busy`, and mfhi/mflo read `hi`/`lo` directly. Operand width is parametrised.

## Interface
- `WIDTH`, 32, operand and HI/LO width; must be ≥ 4
- `clk` in 1, rising-edge clock
- `reset` in 1, synchronous, active-high
- `start` in 1, launch operation `op` on `srca`/`srcb`
- `op` in 2, `mdu_op_t`: MULT=0, MULTU=1, DIV=2, DIVU=3
- `srca` in WIDTH, multiplicand / dividend (rs)
- `srcb` in WIDTH, multiplier / divisor (rt)
- `wr_hi` in 1, mthi: load `wdata` into HI
- `wr_lo` in 1, mtlo: load `wdata` into LO
- `wdata` in WIDTH, mthi/mtlo data
- `busy` out 1, operation in flight
- `done` out 1, one-cycle pulse when HI/LO hold a new result
- `hi` out WIDTH, HI register
- `lo` out WIDTH, LO register

## Operation
- FSM states:
  - IDLE → RUN on `start`: operands captured, signs recorded for MULT/DIV, magnitudes taken, counter cleared.
  - RUN: one shift-add (multiply) or restoring-subtract (divide) step per cycle, over WIDTH cycles; → FINISH when the counter reaches WIDTH-1.
  - FINISH: sign correction, HI/LO written, `done`←1; → IDLE.
- Results:
  - Multiply: {HI,LO} = full 2·WIDTH-bit product, two's complement for MULT.
  - Divide: LO = quotient and HI = remainder, truncating toward zero; the remainder takes the dividend's sign.
  - Divide by zero (DIV/DIVU): LO = all ones, HI = `srca` unchanged.
  - DIV of most-negative by −1: LO = most-negative, HI = 0.
- HI/LO moves:
  - `wr_hi`/`wr_lo` take effect at the next edge, only in IDLE with `start` low. Both may be asserted together.
  - In any other case the moves are ignored; hazard logic prevents them.
  - `start` in IDLE with `wr_*` high in the same cycle: `start` wins and the writes are dropped.
- `start` outside IDLE is ignored; the in-flight operation is unaffected.
- Reset state: IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, counter=0. Reset mid-operation aborts it with no HI/LO update.

## Timing
- E0 is the edge at which `start` is sampled in IDLE.
- `busy` is high from after E0 until E(WIDTH+1), i.e. WIDTH+1 cycles.
- HI/LO update at E(WIDTH+1). `done` is high for exactly the following cycle, with `busy` low.
- Total latency: WIDTH+1 edges, which is 33 for WIDTH=32.
- A `start` during the `done` cycle is accepted (back-to-back).
- `hi`/`lo` are registered outputs and stay stable throughout RUN and FINISH.
- An mthi/mtlo result is visible the cycle after the write edge.

## Structure
- Shared package `mips_pkg`: `mdu_op_t` enum, and the `mdu_state_t` enum (IDLE, RUN, FINISH).
- One sub-module is natural: `mdu_signfix`, purely combinational.
  - Inputs: raw product or quotient/remainder plus recorded signs.
  - Outputs: corrected HI/LO values, including the divide-by-zero and overflow overrides.
- FSM, counter and datapath registers stay in `mips_muldiv`.

## Test plan
All scenarios use WIDTH=32.
- MULT −3 × 7: `done` 33 edges after E0; `hi`=FFFFFFFF, `lo`=FFFFFFEB. MULTU FFFFFFFF × FFFFFFFF: `hi`=FFFFFFFE, `lo`=00000001.
- DIV −7 / 2: `lo`=FFFFFFFD, `hi`=FFFFFFFF. DIVU 100 / 7: `lo`=0000000E, `hi`=00000002.
- Boundary divides: DIV 5 / 0 gives `lo`=FFFFFFFF, `hi`=00000005. DIV 80000000 / FFFFFFFF gives `lo`=80000000, `hi`=0.
- Write handling:
  - mthi 12345678 then mtlo 9ABCDEF0 → registers read back those values.
  - `start` pulsed mid-RUN → ignored; the original result and timing are unchanged.
  - `wr_hi` concurrent with `start` → dropped.
- `reset` asserted at cycle 10 of a MULT → `busy`=0, `hi`=`lo`=0 next cycle, and no `done`.
- Back-to-back: a second MULTU `start` issued in the `done` cycle completes 33 edges later with the correct product.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared types for the MIPS multiply/divide unit
package mips_pkg;
  typedef enum logic [1:0] {MULT = 2'd0, MULTU = 2'd1, DIV = 2'd2, DIVU = 2'd3} mdu_op_t;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FINISH = 2'd2} mdu_state_t;
endpackage

// File: rtl/mdu_signfix.sv
// mdu_signfix: turns the unsigned iterative result into architectural HI/LO values
module mdu_signfix
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  mdu_op_t            op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2*WIDTH-1:0] p,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  logic sa, sb, div0, ovf;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] q, r;
  // negate magnitudes by recorded signs, then apply divide-by-zero and overflow overrides
  always_comb begin
    sa = (op == MULT || op == DIV) && a[WIDTH-1];
    sb = (op == MULT || op == DIV) && b[WIDTH-1];
    prod = (sa ^ sb) ? -p : p;
    q = (sa ^ sb) ? -p[WIDTH-1:0] : p[WIDTH-1:0];
    r = sa ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
    div0 = b == '0;
    ovf = op == DIV && a == MIN && b == '1;
    {hi, lo} = !op[1] ? prod : div0 ? {a, {WIDTH{1'b1}}} : ovf ? {{WIDTH{1'b0}}, MIN} : {r, q};
  end
endmodule

// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative multiply/divide unit with HI/LO registers
module mips_muldiv
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  mdu_state_t state, state_n;
  mdu_op_t opc, op_r;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_r, b_r, m, ma, mb, hi_n, lo_n;
  logic [2*WIDTH-1:0] p, p_n;
  logic [WIDTH:0] sum, t, diff;
  logic sgn;
  // operand magnitudes and one shift-add / restoring-subtract step
  always_comb begin
    opc = mdu_op_t'(op);
    sgn = opc == MULT || opc == DIV;
    ma = (sgn && srca[WIDTH-1]) ? -srca : srca;
    mb = (sgn && srcb[WIDTH-1]) ? -srcb : srcb;
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
    t = p[2*WIDTH-1:WIDTH-1];
    diff = t - {1'b0, m};
    p_n = !op_r[1] ? {sum, p[WIDTH-1:1]}
                   : {diff[WIDTH] ? t[WIDTH-1:0] : diff[WIDTH-1:0], p[WIDTH-2:0], ~diff[WIDTH]};
  end
  // next-state logic
  always_comb begin
    state_n = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (cnt == LAST ? FINISH : RUN) : IDLE;
    busy = state != IDLE;
  end
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  // datapath: multiplicand/divisor in m, product or {remainder, quotient} shifting through p
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
    end else begin
      done <= state == FINISH;
      if (state == IDLE && start) begin
        op_r <= opc;
        a_r <= srca;
        b_r <= srcb;
        m <= opc[1] ? mb : ma;
        p <= {{WIDTH{1'b0}}, opc[1] ? ma : mb};
        cnt <= '0;
      end
      if (state == RUN) begin
        p <= p_n;
        cnt <= cnt + 1'b1;
      end
      if (state == FINISH) begin
        hi <= hi_n;
        lo <= lo_n;
      end
      if (state == IDLE && !start && wr_hi) hi <= wdata;
      if (state == IDLE && !start && wr_lo) lo <= wdata;
    end
  end
  mdu_signfix #(.WIDTH(WIDTH)) u_fix (
    .op(op_r),
    .a (a_r),
    .b (b_r),
    .p (p),
    .hi(hi_n),
    .lo(lo_n)
  );
endmodule

// File: tb/tb_mips_muldiv.sv
// tb_mips_muldiv: scoreboard bench for the multiply/divide unit
module tb_mips_muldiv;
  import mips_pkg::*;
  typedef struct {logic [63:0] res; int cyc;} exp_t;
  logic clk = 0, reset = 1, start = 0, wr_hi = 0, wr_lo = 0, busy, done;
  logic [1:0] op = 0;
  logic [31:0] srca = 0, srcb = 0, wdata = 0, hi, lo;
  int cyc = 0, tests = 0, fails = 0;
  exp_t sb[$];
  mips_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int qi, ri;
    if (o == 2'd0) return 64'(longint'(int'(a)) * longint'(int'(b)));
    if (o == 2'd1) return {32'b0, a} * {32'b0, b};
    if (b == 0) return {a, 32'hFFFFFFFF};
    if (o == 2'd3) return {a % b, a / b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
    qi = int'(a) / int'(b);
    ri = int'(a) % int'(b);
    return {32'(ri), 32'(qi)};
  endfunction
  // compare every completion against the oldest outstanding expectation
  always @(negedge clk) if (done) begin
    check("done_busy", 64'(busy), 64'd0);
    if (sb.size() == 0) check("spurious_done", 64'd1, 64'd0);
    else begin
      check("result", {hi, lo}, sb[0].res);
      check("latency", 64'(cyc), 64'(sb[0].cyc));
      void'(sb.pop_front());
    end
  end
  task automatic drive(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1; op = o; srca = a; srcb = b;
    @(negedge clk);
    start = 0;
  endtask
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    sb.push_back('{exp, cyc + 34});
    drive(o, a, b);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 200 && (sb.size() != 0 || busy || done); i++) @(negedge clk);
    check("timeout", 64'(sb.size()), 64'd0);
  endtask
  task automatic move(input logic h, input logic l, input logic [31:0] d);
    wr_hi = h; wr_lo = l; wdata = d;
    @(negedge clk);
    wr_hi = 0; wr_lo = 0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset = 0;
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_busy_done", {62'd0, busy, done}, 64'd0);
    issue(2'd0, 32'hFFFFFFFD, 32'd7, {32'hFFFFFFFF, 32'hFFFFFFEB});
    wait_idle();
    issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001});
    wait_idle();
    issue(2'd2, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
    wait_idle();
    issue(2'd3, 32'd100, 32'd7, {32'h2, 32'hE});
    wait_idle();
    issue(2'd2, 32'd5, 32'd0, {32'h5, 32'hFFFFFFFF});
    wait_idle();
    issue(2'd2, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000});
    wait_idle();
    move(1, 0, 32'h12345678);
    check("mthi", 64'(hi), 64'h12345678);
    move(0, 1, 32'h9ABCDEF0);
    check("mtlo", {hi, lo}, {32'h12345678, 32'h9ABCDEF0});
    move(1, 1, 32'h11111111);
    check("mthilo", {hi, lo}, {32'h11111111, 32'h11111111});
    issue(2'd0, 32'd1234, 32'hFFFFD3A2, model(2'd0, 32'd1234, 32'hFFFFD3A2));
    repeat (10) @(negedge clk);
    check("run_stable", {hi, lo}, {32'h11111111, 32'h11111111});
    drive(2'd3, 32'd99, 32'd3);
    wait_idle();
    move(1, 0, 32'h22222222);
    wr_hi = 1; wdata = 32'hDEADBEEF;
    issue(2'd1, 32'd2, 32'd3, {32'h0, 32'h6});
    wr_hi = 0;
    check("start_drops_wr", 64'(hi), 64'h22222222);
    wait_idle();
    drive(2'd0, 32'd77, 32'd88);
    repeat (9) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("abort_state", {30'd0, busy, done, hi}, 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    repeat (40) @(negedge clk);
    issue(2'd1, 32'hCAFEBABE, 32'h10001, model(2'd1, 32'hCAFEBABE, 32'h10001));
    for (int i = 0; i < 60 && !done; i++) @(negedge clk);
    check("b2b_first_done", 64'(done), 64'd1);
    issue(2'd1, 32'h87654321, 32'hFEDCBA98, model(2'd1, 32'h87654321, 32'hFEDCBA98));
    wait_idle();
    for (int i = 0; i < 8; i++) begin
      logic [1:0] o;
      logic [31:0] a, b;
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i == 3) ? 32'd0 : $urandom >> $urandom_range(0, 28);
      if (i[0]) b = -b;
      issue(o, a, b, model(o, a, b));
      wait_idle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
